// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions: datapath widths and load-kind encoding.
package cpu_defs;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LB        = 3'd1,
    LBU       = 3'd2,
    LH        = 3'd3,
    LHU       = 3'd4,
    LW        = 3'd5
  } load_op_e;
endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake plus the register-file, forwarding and trace buses.
interface wb_stage_if #(
  parameter int DW = cpu_defs::DW,
  parameter int AW = cpu_defs::AW
) ();
  import cpu_defs::*;

  logic          stall;
  logic          flush;
  logic          mem_valid;
  logic [DW-1:0] mem_pc;
  logic          mem_rf_we;
  logic [AW-1:0] mem_rf_waddr;
  logic [DW-1:0] mem_result;
  load_op_e      mem_load_op;
  logic [DW-1:0] data_sram_rdata;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          fwd_we;
  logic [AW-1:0] fwd_waddr;
  logic [DW-1:0] fwd_wdata;
  logic [DW-1:0] debug_wb_pc;
  logic [3:0]    debug_wb_rf_wen;
  logic [AW-1:0] debug_wb_rf_wnum;
  logic [DW-1:0] debug_wb_rf_wdata;

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr,
           mem_result, mem_load_op, data_sram_rdata,
    input  rf_we, rf_waddr, rf_wdata, fwd_we, fwd_waddr, fwd_wdata,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr,
           mem_result, mem_load_op, data_sram_rdata,
    output rf_we, rf_waddr, rf_wdata, fwd_we, fwd_waddr, fwd_wdata,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load alignment/extension; shared with the uncached-load path.
module load_align
  import cpu_defs::*;
#(
  parameter int DW = cpu_defs::DW
) (
  input  load_op_e      op,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] raw,
  input  logic [DW-1:0] result,
  output logic [DW-1:0] wdata
);
  logic [7:0]  b;
  logic [15:0] h;

  // pick byte/halfword by address offset, then extend per load kind
  always_comb begin
    b     = raw[8*addr +: 8];
    h     = raw[16*addr[1] +: 16];
    wdata = result;
    case (op)
      LB:      wdata = {{(DW-8){b[7]}}, b};
      LBU:     wdata = {{(DW-8){1'b0}}, b};
      LH:      wdata = {{(DW-16){h[15]}}, h};
      LHU:     wdata = {{(DW-16){1'b0}}, h};
      LW:      wdata = raw;
      default: wdata = result;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM result, captures one-cycle SRAM data across
// stalls, drives register-file write, ID forwarding and debug trace.
module wb_stage
  import cpu_defs::*;
#(
  parameter int DW = cpu_defs::DW,
  parameter int AW = cpu_defs::AW
) (
  input logic       clk,
  input logic       resetn,
  wb_stage_if.slave bus
);
  logic          wb_valid;
  logic [DW-1:0] pc_r;
  logic          we_r;
  logic [AW-1:0] waddr_r;
  logic [DW-1:0] result_r;
  load_op_e      op_r;
  logic          fresh_r;   // SRAM data for this entry is on the bus this cycle
  logic [DW-1:0] hold_r;    // SRAM data saved once the entry stalls
  logic [DW-1:0] raw;
  logic [DW-1:0] wdata;
  logic          commit;

  // entry register: flush beats stall; first stalled edge snapshots SRAM data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      pc_r     <= '0;
      we_r     <= 1'b0;
      waddr_r  <= '0;
      result_r <= '0;
      op_r     <= LOAD_NONE;
      fresh_r  <= 1'b0;
      hold_r   <= '0;
    end else if (bus.flush) begin
      wb_valid <= 1'b0;
      fresh_r  <= 1'b0;
    end else if (!bus.stall) begin
      wb_valid <= bus.mem_valid;
      pc_r     <= bus.mem_pc;
      we_r     <= bus.mem_rf_we;
      waddr_r  <= bus.mem_rf_waddr;
      result_r <= bus.mem_result;
      op_r     <= bus.mem_load_op;
      fresh_r  <= bus.mem_valid;
    end else if (fresh_r) begin
      hold_r  <= bus.data_sram_rdata;
      fresh_r <= 1'b0;
    end
  end

  assign raw = fresh_r ? bus.data_sram_rdata : hold_r;

  load_align #(.DW(DW)) u_align (
    .op     (op_r),
    .addr   (result_r[1:0]),
    .raw    (raw),
    .result (result_r),
    .wdata  (wdata)
  );

  // write commits only in the cycle the entry leaves WB
  assign commit = wb_valid & we_r & ~bus.stall & ~bus.flush;

  assign bus.rf_we             = commit;
  assign bus.rf_waddr          = waddr_r;
  assign bus.rf_wdata          = wdata;
  assign bus.fwd_we            = wb_valid & we_r;
  assign bus.fwd_waddr         = waddr_r;
  assign bus.fwd_wdata         = wdata;
  assign bus.debug_wb_pc       = pc_r;
  assign bus.debug_wb_rf_wen   = {4{commit}};
  assign bus.debug_wb_rf_wnum  = waddr_r;
  assign bus.debug_wb_rf_wdata = wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage against a behavioural entry model.
module tb_wb_stage;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if bus ();
  wb_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model of the instruction sitting in WB; word = the load's SRAM data
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] result;
    load_op_e    op;
    logic [31:0] word;
    int          age;
  } ent_t;
  ent_t m;

  logic [31:0] obs_wdata, obs_fwd_wdata;
  bit          obs_rfwe, obs_fwdwe;
  int          wr_cnt;

  function automatic logic [31:0] ref_data(input ent_t e);
    int v;
    int sh;
    case (e.op)
      LB, LBU: begin
        sh = 8 * int'(e.result[1:0]);
        v  = int'((e.word >> sh) & 32'hFF);
        if (e.op == LB && v >= 128) v -= 256;
        return 32'(v);
      end
      LH, LHU: begin
        sh = 16 * int'(e.result[1]);
        v  = int'((e.word >> sh) & 32'hFFFF);
        if (e.op == LH && v >= 32768) v -= 65536;
        return 32'(v);
      end
      LW:      return e.word;
      default: return e.result;
    endcase
  endfunction

  task automatic model_clear();
    m.valid = 0; m.pc = '0; m.we = 0; m.waddr = '0;
    m.result = '0; m.op = LOAD_NONE; m.word = '0; m.age = 1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_rf_we"},   32'(bus.rf_we), 0);
    chk({tag, "_rf_wa"},   32'(bus.rf_waddr), 0);
    chk({tag, "_rf_wd"},   bus.rf_wdata, 0);
    chk({tag, "_fwd_we"},  32'(bus.fwd_we), 0);
    chk({tag, "_fwd_wa"},  32'(bus.fwd_waddr), 0);
    chk({tag, "_fwd_wd"},  bus.fwd_wdata, 0);
    chk({tag, "_dbg_pc"},  bus.debug_wb_pc, 0);
    chk({tag, "_dbg_wen"}, 32'(bus.debug_wb_rf_wen), 0);
    chk({tag, "_dbg_num"}, 32'(bus.debug_wb_rf_wnum), 0);
    chk({tag, "_dbg_wd"},  bus.debug_wb_rf_wdata, 0);
  endtask

  task automatic check_outputs(input bit st, input bit fl);
    bit ew;
    ew = m.valid && m.we && !st && !fl;
    chk("rf_we",   32'(bus.rf_we), 32'(ew));
    chk("fwd_we",  32'(bus.fwd_we), 32'(m.valid && m.we));
    chk("dbg_wen", 32'(bus.debug_wb_rf_wen), ew ? 32'hF : 32'h0);
    if (m.valid) begin
      chk("rf_waddr",  32'(bus.rf_waddr), 32'(m.waddr));
      chk("fwd_waddr", 32'(bus.fwd_waddr), 32'(m.waddr));
      chk("dbg_wnum",  32'(bus.debug_wb_rf_wnum), 32'(m.waddr));
      chk("rf_wdata",  bus.rf_wdata, ref_data(m));
      chk("fwd_wdata", bus.fwd_wdata, ref_data(m));
      chk("dbg_wdata", bus.debug_wb_rf_wdata, ref_data(m));
      chk("dbg_pc",    bus.debug_wb_pc, m.pc);
    end
    obs_wdata     = bus.rf_wdata;
    obs_fwd_wdata = bus.fwd_wdata;
    obs_rfwe      = bus.rf_we;
    obs_fwdwe     = bus.fwd_we;
    if (bus.rf_we) wr_cnt++;
  endtask

  // one WB cycle: drive at posedge+1, check at negedge, advance model at posedge
  task automatic cycle(input bit st, input bit fl, input bit mv, input bit we,
                       input logic [4:0] wa, input logic [31:0] pc,
                       input logic [31:0] res, input load_op_e op,
                       input logic [31:0] word);
    bus.stall = st; bus.flush = fl; bus.mem_valid = mv; bus.mem_rf_we = we;
    bus.mem_rf_waddr = wa; bus.mem_pc = pc; bus.mem_result = res;
    bus.mem_load_op = op;
    bus.data_sram_rdata = (m.age == 0) ? m.word : $urandom;
    @(negedge clk);
    check_outputs(st, fl);
    @(posedge clk);
    if (fl) m.valid = 0;
    else if (!st) begin
      m.valid = mv; m.we = we; m.waddr = wa; m.pc = pc; m.result = res;
      m.op = op; m.word = word; m.age = 0;
    end else m.age++;
    #1;
  endtask

  task automatic bubble();
    cycle(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, LOAD_NONE, 32'h0);
  endtask

  task automatic load_test(input load_op_e op, input logic [1:0] a,
                           input logic [31:0] exp, input string tag);
    cycle(0, 0, 1, 1, 5'd3, 32'hBFC0_0100, {30'h0400_0000, a}, op, 32'h80FF_7F01);
    bubble();
    chk(tag, obs_wdata, exp);
    chk({tag, "_we"}, 32'(obs_rfwe), 1);
  endtask

  initial begin
    model_clear();
    bus.stall = 0; bus.flush = 0; bus.mem_valid = 0; bus.mem_pc = '0;
    bus.mem_rf_we = 0; bus.mem_rf_waddr = '0; bus.mem_result = '0;
    bus.mem_load_op = LOAD_NONE; bus.data_sram_rdata = 32'h5A5A_5A5A;
    #12;
    zero_check("reset");
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // ALU result write
    cycle(0, 0, 1, 1, 5'd8, 32'hBFC0_0000, 32'h1234_5678, LOAD_NONE, 32'h0);
    bubble();
    chk("alu_wdata", obs_wdata, 32'h1234_5678);
    chk("alu_we", 32'(obs_rfwe), 1);

    // load alignment
    load_test(LB,  2'd3, 32'hFFFF_FF80, "lb3");
    load_test(LBU, 2'd3, 32'h0000_0080, "lbu3");
    load_test(LH,  2'd2, 32'hFFFF_80FF, "lh2");
    load_test(LHU, 2'd0, 32'h0000_7F01, "lhu0");
    load_test(LW,  2'd0, 32'h80FF_7F01, "lw");

    // LW held 3 cycles; SRAM data only valid in the first
    wr_cnt = 0;
    cycle(0, 0, 1, 1, 5'd9, 32'hBFC0_0200, 32'h1000_0000, LW, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 1, 5'd1, 32'h0, 32'h0, LOAD_NONE, 32'h0);
      chk("stall_rfwe", 32'(obs_rfwe), 0);
      chk("stall_fwdwe", 32'(obs_fwdwe), 1);
      chk("stall_fwd", obs_fwd_wdata, 32'hDEAD_BEEF);
    end
    bubble();
    chk("stall_pulse", 32'(obs_rfwe), 1);
    chk("stall_data", obs_wdata, 32'hDEAD_BEEF);
    bubble();
    chk("stall_writes", 32'(wr_cnt), 1);

    // flush while stalled
    wr_cnt = 0;
    cycle(0, 0, 1, 1, 5'd10, 32'hBFC0_0300, 32'h1111_2222, LOAD_NONE, 32'h0);
    cycle(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, LOAD_NONE, 32'h0);
    cycle(1, 1, 0, 0, 5'd0, 32'h0, 32'h0, LOAD_NONE, 32'h0);
    bubble();
    chk("flush_valid", 32'(obs_fwdwe), 0);
    chk("flush_writes", 32'(wr_cnt), 0);

    // flush and stall together on a fresh entry
    wr_cnt = 0;
    cycle(0, 0, 1, 1, 5'd11, 32'hBFC0_0400, 32'h3333_4444, LOAD_NONE, 32'h0);
    cycle(1, 1, 0, 0, 5'd0, 32'h0, 32'h0, LOAD_NONE, 32'h0);
    bubble();
    chk("fs_valid", 32'(obs_fwdwe), 0);
    chk("fs_writes", 32'(wr_cnt), 0);

    // reset mid-stall of an LW
    cycle(0, 0, 1, 1, 5'd12, 32'hBFC0_0500, 32'h1000_0004, LW, 32'hCAFE_F00D);
    cycle(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, LOAD_NONE, 32'h0);
    resetn = 1'b0;
    #1;
    zero_check("midrst");
    model_clear();
    bus.stall = 0; bus.mem_valid = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++)
      cycle(bit'($urandom_range(0, 1)), 0, 0, 1, 5'd12, 32'h0, 32'h0, LW, 32'h0);
    chk("post_rst_writes", 32'(wr_cnt), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
            bit'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
            load_op_e'($urandom_range(0, 5)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back pipeline stage of the five-stage MIPS core. It sits between the MEM stage and the register file. It latches the MEM result and aligns and extends load data from the synchronous data SRAM. It drives the register-file write port (we/waddr/wdata), the ID-stage forwarding bus and the debug trace. It holds its entry under stall without losing SRAM read data, which is valid for only one cycle.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- stall  in  1  hold WB entry (from hazard control)
- flush  in  1  discard WB entry (exception/eret)
- mem_valid  in  1  MEM has an instruction for WB
- mem_pc  in  DW  PC of that instruction
- mem_rf_we  in  1  instruction writes a GPR
- mem_rf_waddr  in  AW  destination GPR
- mem_result  in  DW  ALU result, or byte address for loads
- mem_load_op  in  3  load kind (package encoding)
- data_sram_rdata  in  DW  SRAM read data; valid only in the first cycle after an entry is latched
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- fwd_we  out  1  WB holds a pending GPR write
- fwd_waddr  out  AW  forwarding destination
- fwd_wdata  out  DW  forwarding data
- debug_wb_pc  out  DW  trace PC
- debug_wb_rf_wen  out  4  trace write-enable, all four bits equal rf_we
- debug_wb_rf_wnum  out  AW  trace register
- debug_wb_rf_wdata  out  DW  trace data

## Operation
- Entry registers: wb_valid, pc_r, we_r, waddr_r, result_r, op_r, fresh_r, hold_r. Reset clears all of them to 0.
- Each clock edge, in priority order:
  - flush: wb_valid<=0; other fields are don't-care.
  - else ~stall: load all fields from mem_*; wb_valid<=mem_valid; fresh_r<=mem_valid.
  - else (stall): fields hold. If fresh_r=1: hold_r<=data_sram_rdata and fresh_r<=0.
- Raw load word: data_sram_rdata when fresh_r=1, else hold_r.
- Alignment uses result_r[1:0]:
  - LB/LBU: select byte at offset [1:0]; sign- or zero-extend.
  - LH/LHU: select halfword by result_r[1]; sign- or zero-extend.
  - LW: raw word.
  - NONE: result_r.
  - Misalignment is trapped upstream; WB does not check it.
- Final data wdata feeds rf_wdata, fwd_wdata and debug_wb_rf_wdata.
- fwd_we = wb_valid & we_r. It does not depend on stall, so ID can bypass from a held entry.
- rf_we = wb_valid & we_r & ~stall & ~flush. A write commits exactly once: in the cycle the entry leaves WB.
- waddr=0 is passed through unchanged; the register file ignores it.

## Timing
- Latency: MEM→WB is 1 cycle; register-file write is at the clock edge ending the WB cycle.
- All outputs are 0 during reset. All outputs are combinational from WB registers and stall/flush/rdata; none is registered again.
- Stall of N cycles: rf_we stays 0 for N cycles. wdata stays stable using hold_r. rf_we pulses for one cycle on the first unstalled cycle.
- Flush and stall together: flush wins.
- mem_valid=0 while not stalled: a bubble enters; all enables are 0.
- resetn asserted mid-stall: hold_r and fresh_r clear; no write is emitted.

## Structure
- Shared package cpu_defs holds:
  - LOAD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5 (3-bit enum)
  - DW/AW constants
- Sub-module load_align (combinational): inputs op, addr[1:0], raw word, result; output wdata. It is reused by the uncached-load path.

## Test plan
- ALU op: mem_result=0x1234_5678, waddr=8, load NONE, no stall → next cycle rf_we=1, waddr=8, wdata=0x1234_5678; debug_wb_rf_wen=4'hF.
- Loads, rdata=0x80FF_7F01:
  - LB @addr[1:0]=3 → 0xFFFF_FF80
  - LBU @3 → 0x80
  - LH @2 → 0xFFFF_80FF
  - LHU @0 → 0x7F01
  - LW → 0x80FF_7F01
- LW with 3-cycle stall:
  - data_sram_rdata=0xDEAD_BEEF in the first cycle, garbage afterwards.
  - rf_we=0 for 3 cycles; fwd_we=1 with fwd_wdata=0xDEAD_BEEF throughout.
  - Single rf_we pulse with 0xDEAD_BEEF.
- Flush while an entry is stalled → wb_valid=0 next cycle; no rf_we pulse ever issued for it.
- Flush and stall asserted together → flush wins: wb_valid=0 next cycle, no write.
- resetn pulled low mid-stall of an LW → all outputs 0 immediately; after release, zero writes until a new mem_valid entry arrives.
